// File: rtl/spi_rxc_pkg.sv
// Shared definitions for the SPI receive core: frame-size encoding, phase enum
// and helpers that derive frame length and data mask from df.
package spi_rxc_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 13;
    localparam int unsigned BIT_CNT_W = 5;
    localparam int unsigned LEN_W     = 6;

    localparam logic [1:0] DF_8  = 2'b00;
    localparam logic [1:0] DF_16 = 2'b01;
    localparam logic [1:0] DF_32 = 2'b10;

    typedef enum logic {
        DATA = 1'b0,
        CRC  = 1'b1
    } phase_e;

    // Reserved encoding 11 falls through to 32 bits.
    function automatic logic [LEN_W-1:0] frame_len(input logic [1:0] df);
        case (df)
            DF_8:    frame_len = LEN_W'(8);
            DF_16:   frame_len = LEN_W'(16);
            default: frame_len = LEN_W'(32);
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] mask_n(input logic [1:0] df);
        case (df)
            DF_8:    mask_n = DATA_W'(32'h0000_00FF);
            DF_16:   mask_n = DATA_W'(32'h0000_FFFF);
            default: mask_n = DATA_W'(32'hFFFF_FFFF);
        endcase
    endfunction

endpackage

// File: rtl/spi_rx_crc_ser.sv
// One-bit-per-clock serial CRC (non-reflected) of width set by mask; clr makes
// the step start from zero so a new transfer needs no extra clock edge.
module spi_rx_crc_ser
    import spi_rxc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              din,
    input  logic [DATA_W-1:0] mask,
    input  logic [DATA_W-1:0] poly,
    output logic [DATA_W-1:0] crc
);

    logic [DATA_W-1:0] crc_q;
    logic [DATA_W-1:0] crc_d;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] top;
    logic              fb;

    // Top bit of the mask selects the CRC MSB for the active width.
    always_comb begin
        cur   = clr ? '0 : crc_q;
        top   = mask ^ (mask >> 1);
        fb    = (|(cur & top)) ^ din;
        crc_d = crc_q;
        if (en) begin
            crc_d = ((cur << 1) & mask) ^ (fb ? (poly & mask) : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/spi_rxc.sv
// SPI receive core: deserialises shift_in per clk_rx edge into 8/16/32-bit
// words, counts frames per transfer and tracks the DATA/CRC phase.
module spi_rxc
    import spi_rxc_pkg::*;
(
    input  logic              clk_rx,
    input  logic              spi_rx_rstn,
    input  logic [1:0]        df,
    input  logic [CNT_W-1:0]  spi_tnum_max,
    input  logic              lsbf,
    input  logic              crc_en,
    input  logic              rxonly,
    input  logic              shift_in,
    input  logic [DATA_W-1:0] crc_poly,
    output logic [DATA_W-1:0] rx_crc_data_out,
    output logic [DATA_W-1:0] spi_rx_data,
    output logic              rx_num_max_en,
    output logic              rx_crc_en,
    output logic              rx_busy
);

    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    phase_e               phase_q, phase_d;
    logic [DATA_W-1:0]    sreg_q, sreg_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 num_max_q, num_max_d;
    logic                 crc_ph_q, crc_ph_d;
    logic                 busy_q, busy_d;

    logic [LEN_W-1:0]     flen;
    logic [DATA_W-1:0]    mask;
    logic [DATA_W-1:0]    word;
    logic                 last;
    logic                 crc_step;
    logic                 crc_clr;

    always_comb begin
        flen        = frame_len(df);
        mask        = mask_n(df);
        // >= keeps the counter wrapping if df shrinks mid-frame.
        last        = {1'b0, bit_cnt_q} >= (flen - LEN_W'(1));
        word        = lsbf ? (sreg_q | (DATA_W'(shift_in) << bit_cnt_q))
                           : {sreg_q[DATA_W-2:0], shift_in};
        crc_step    = crc_en && (phase_q == DATA);
        crc_clr     = (bit_cnt_q == '0) && (frame_cnt_q == '0);

        bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        sreg_d      = word;
        data_d      = data_q;

        // Word completes on the edge sampling its last bit.
        if (last) begin
            bit_cnt_d = '0;
            sreg_d    = '0;
            data_d    = word & mask;
            if (phase_q == CRC) begin
                phase_d     = DATA;
                frame_cnt_d = '0;
            end else if (frame_cnt_q == spi_tnum_max) begin
                if (crc_en) begin
                    phase_d     = CRC;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end else begin
                    frame_cnt_d = '0;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end

        num_max_d = (phase_d == DATA) && (frame_cnt_d == spi_tnum_max);
        crc_ph_d  = (phase_d == CRC);
        busy_d    = (bit_cnt_d != '0) ||
                    (rxonly && ((frame_cnt_d != '0) || (phase_d == CRC)));
    end

    always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
        if (!spi_rx_rstn) begin
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            phase_q     <= DATA;
            sreg_q      <= '0;
            data_q      <= '0;
            num_max_q   <= 1'b0;
            crc_ph_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            sreg_q      <= sreg_d;
            data_q      <= data_d;
            num_max_q   <= num_max_d;
            crc_ph_q    <= crc_ph_d;
            busy_q      <= busy_d;
        end
    end

    spi_rx_crc_ser u_crc (
        .clk   (clk_rx),
        .rst_n (spi_rx_rstn),
        .en    (crc_step),
        .clr   (crc_clr),
        .din   (shift_in),
        .mask  (mask),
        .poly  (crc_poly),
        .crc   (rx_crc_data_out)
    );

    assign spi_rx_data   = data_q;
    assign rx_num_max_en = num_max_q;
    assign rx_crc_en     = crc_ph_q;
    assign rx_busy       = busy_q;

endmodule

// File: tb/tb_spi_rxc.sv
// Self-checking bench for spi_rxc: directed frames plus randomized transfers
// checked against a bit-serial reference model of frames, phases and CRC.
module tb_spi_rxc;

    logic        clk_rx = 1'b0;
    logic        spi_rx_rstn = 1'b1;
    logic [1:0]  df = 2'b00;
    logic [12:0] spi_tnum_max = '0;
    logic        lsbf = 1'b0;
    logic        crc_en = 1'b0;
    logic        rxonly = 1'b0;
    logic        shift_in = 1'b0;
    logic [31:0] crc_poly = '0;
    logic [31:0] rx_crc_data_out;
    logic [31:0] spi_rx_data;
    logic        rx_num_max_en;
    logic        rx_crc_en;
    logic        rx_busy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_crc = '0;

    spi_rxc dut (
        .clk_rx          (clk_rx),
        .spi_rx_rstn     (spi_rx_rstn),
        .df              (df),
        .spi_tnum_max    (spi_tnum_max),
        .lsbf            (lsbf),
        .crc_en          (crc_en),
        .rxonly          (rxonly),
        .shift_in        (shift_in),
        .crc_poly        (crc_poly),
        .rx_crc_data_out (rx_crc_data_out),
        .spi_rx_data     (spi_rx_data),
        .rx_num_max_en   (rx_num_max_en),
        .rx_crc_en       (rx_crc_en),
        .rx_busy         (rx_busy)
    );

    function automatic int len_of(input logic [1:0] d);
        return (d == 2'b00) ? 8 : (d == 2'b01) ? 16 : 32;
    endfunction

    function automatic logic [31:0] mask_of(input int n);
        return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic wire_bit(input logic [31:0] w, input int n, input bit lsb, input int i);
        return lsb ? w[i] : w[n-1-i];
    endfunction

    // Polynomial division of the word's bits, taken in wire order.
    function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [31:0] w,
                                            input int n, input bit lsb, input logic [31:0] p);
        logic [31:0] m;
        logic        fb;
        m = mask_of(n);
        for (int i = 0; i < n; i++) begin
            fb = c[n-1] ^ wire_bit(w, n, lsb, i);
            c  = ((c << 1) & m) ^ (fb ? (p & m) : 32'd0);
        end
        return c;
    endfunction

    // One serial clock pulse; outputs are sampled after the falling edge.
    task automatic clk_bit(input logic b);
        shift_in = b;
        #5 clk_rx = 1'b1;
        #5 clk_rx = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input bit lsb,
                             input int from, input int to);
        for (int i = from; i < to; i++) clk_bit(wire_bit(w, n, lsb, i));
    endtask

    task automatic do_reset();
        spi_rx_rstn = 1'b0;
        exp_crc     = '0;
        #4;
        spi_rx_rstn = 1'b1;
        #1;
    endtask

    task automatic run_transfer(input string name, input logic [1:0] d, input bit lsb,
                                input bit ce, input bit ro, input logic [12:0] tmax,
                                input logic [31:0] poly, input logic [31:0] fr[$],
                                input bit send_crc);
        int          n;
        logic [31:0] w;
        logic        e_max;
        n = len_of(d);
        df = d; lsbf = lsb; crc_en = ce; rxonly = ro; spi_tnum_max = tmax; crc_poly = poly;
        for (int k = 0; k <= int'(tmax); k++) begin
            w = fr[k] & mask_of(n);
            if (k == 0 && ce) exp_crc = '0;
            send_bits(w, n, lsb, 0, n - 1);
            vectors++;
            if (rx_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy_midframe f%0d: got %b exp 1", name, k, rx_busy);
            end
            send_bits(w, n, lsb, n - 1, n);
            if (ce) exp_crc = crc_ref(exp_crc, w, n, lsb, poly);
            e_max = (k < int'(tmax)) ? (k + 1 == int'(tmax)) : (!ce && tmax == 0);
            vectors++;
            if (spi_rx_data !== w) begin
                miscompares++;
                $display("FAIL %s data f%0d: got %h exp %h", name, k, spi_rx_data, w);
            end
            vectors++;
            if (rx_crc_data_out !== exp_crc) begin
                miscompares++;
                $display("FAIL %s crc f%0d: got %h exp %h", name, k, rx_crc_data_out, exp_crc);
            end
            vectors++;
            if (rx_num_max_en !== e_max) begin
                miscompares++;
                $display("FAIL %s num_max f%0d: got %b exp %b", name, k, rx_num_max_en, e_max);
            end
            vectors++;
            if (rx_crc_en !== (k == int'(tmax) && ce)) begin
                miscompares++;
                $display("FAIL %s crc_phase f%0d: got %b exp %b", name, k, rx_crc_en,
                         (k == int'(tmax) && ce));
            end
            vectors++;
            if (rx_busy !== (ro && (k < int'(tmax) || ce))) begin
                miscompares++;
                $display("FAIL %s busy f%0d: got %b exp %b", name, k, rx_busy,
                         (ro && (k < int'(tmax) || ce)));
            end
        end
        if (ce && send_crc) begin
            w = exp_crc;
            send_bits(w, n, lsb, 0, n);
            vectors++;
            if ({spi_rx_data, rx_crc_data_out, rx_crc_en, rx_busy, rx_num_max_en} !==
                {w, exp_crc, 1'b0, 1'b0, (tmax == 0)}) begin
                miscompares++;
                $display("FAIL %s crc_frame: got %h/%h/%b%b%b exp %h/%h/00%b", name,
                         spi_rx_data, rx_crc_data_out, rx_crc_en, rx_busy, rx_num_max_en,
                         w, exp_crc, (tmax == 0));
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({rx_crc_data_out, spi_rx_data, rx_num_max_en, rx_crc_en, rx_busy} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got %h/%h/%b%b%b exp all zero", rx_crc_data_out,
                     spi_rx_data, rx_num_max_en, rx_crc_en, rx_busy);
        end
    endtask

    task automatic test_msb8();
        df = 2'b00; lsbf = 1'b0; crc_en = 1'b0; rxonly = 1'b0; spi_tnum_max = 13'd1;
        do_reset();
        send_bits(32'hA5, 8, 1'b0, 0, 8);
        vectors++;
        if ({spi_rx_data, rx_num_max_en, rx_busy, rx_crc_en} !== {32'h0000_00A5, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL msb8: got %h max=%b busy=%b crcph=%b exp 000000a5 max=1 busy=0 crcph=0",
                     spi_rx_data, rx_num_max_en, rx_busy, rx_crc_en);
        end
    endtask

    task automatic test_lsb16();
        df = 2'b01; lsbf = 1'b1; spi_tnum_max = '0;
        do_reset();
        send_bits(32'hB971, 16, 1'b1, 0, 16);
        vectors++;
        if (spi_rx_data !== 32'h0000_B971) begin
            miscompares++;
            $display("FAIL lsb16: got %h exp 0000b971", spi_rx_data);
        end
    endtask

    task automatic test_msb32();
        df = 2'b10; lsbf = 1'b0;
        do_reset();
        send_bits(32'hC3D2_F1E8, 32, 1'b0, 0, 32);
        vectors++;
        if (spi_rx_data !== 32'hC3D2_F1E8) begin
            miscompares++;
            $display("FAIL msb32: got %h exp c3d2f1e8", spi_rx_data);
        end
    endtask

    task automatic test_crc8();
        logic [31:0] fr[$];
        fr = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
        df = 2'b00;
        do_reset();
        run_transfer("crc8", 2'b00, 1'b0, 1'b1, 1'b0, 13'd3, 32'h07, fr, 1'b0);
        vectors++;
        if ({rx_crc_data_out, rx_crc_en} !== {32'h0000_0025, 1'b1}) begin
            miscompares++;
            $display("FAIL crc8_final: got %h phase=%b exp 00000025 phase=1", rx_crc_data_out, rx_crc_en);
        end
    endtask

    task automatic test_rxonly_crc16();
        logic [31:0] fr[$];
        fr = '{32'hA1B2, 32'hC3D4, 32'hE5F6};
        df = 2'b01;
        do_reset();
        run_transfer("rxonly16", 2'b01, 1'b0, 1'b1, 1'b1, 13'd2, 32'h0007, fr, 1'b0);
        vectors++;
        if ({rx_crc_en, rx_busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL rxonly16_end: got phase=%b busy=%b exp 1 1", rx_crc_en, rx_busy);
        end
    endtask

    // Back-to-back transfers with random configuration, no reset between.
    task automatic test_back_to_back();
        logic [31:0] fr[$];
        logic [1:0]  d;
        logic [12:0] tmax;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            d    = 2'($urandom_range(0, 3));
            tmax = 13'($urandom_range(0, 3));
            fr.delete();
            for (int k = 0; k <= int'(tmax); k++) fr.push_back($urandom);
            run_transfer($sformatf("rand%0d", t), d, 1'($urandom), 1'($urandom), 1'($urandom),
                         tmax, $urandom | 32'h1, fr, 1'b1);
        end
    endtask

    task automatic test_reset_midframe();
        df = 2'b00; lsbf = 1'b0; crc_en = 1'b0; rxonly = 1'b1; spi_tnum_max = '0;
        do_reset();
        send_bits(32'h3C, 8, 1'b0, 0, 8);
        send_bits(32'hFF, 8, 1'b0, 0, 5);
        spi_rx_rstn = 1'b0;
        #1;
        vectors++;
        if ({rx_crc_data_out, spi_rx_data, rx_num_max_en, rx_crc_en, rx_busy} !== '0) begin
            miscompares++;
            $display("FAIL midreset outputs: got %h/%h/%b%b%b exp all zero", rx_crc_data_out,
                     spi_rx_data, rx_num_max_en, rx_crc_en, rx_busy);
        end
        #2 spi_rx_rstn = 1'b1;
        #1;
        send_bits(32'h5A, 8, 1'b0, 0, 8);
        vectors++;
        if ({spi_rx_data, rx_num_max_en, rx_busy} !== {32'h0000_005A, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset next: got %h max=%b busy=%b exp 0000005a max=1 busy=0",
                     spi_rx_data, rx_num_max_en, rx_busy);
        end
    endtask

    initial begin
        test_reset();
        test_msb8();
        test_lsb16();
        test_msb32();
        test_crc8();
        test_rxonly_crc16();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_rxc.md
Name: spi_rxc

Overview:
- SPI receive core: deserialises `shift_in` on each rising edge of the (gated) serial clock `clk_rx` into 8/16/32-bit words.
- Counts data frames per transfer and computes a running serial CRC over the received data bits.
- Flags the last data frame and the CRC phase to the surrounding SPI controller.
- `clk_rx` toggles only while bits are on the wire. All state therefore advances per received bit; no idle cycles are available for post-processing.

Parameters:
- none; widths are fixed: data/CRC 32, frame count 13.

Ports:
- clk_rx  in  1  serial receive clock; sample on rising edge; gated, one edge per bit.
- spi_rx_rstn  in  1  asynchronous active-low reset.
- df  in  2  frame size: 00=8, 01=16, 10=32, 11=32 (reserved, treated as 32).
- spi_tnum_max  in  13  number of data frames per transfer minus 1.
- lsbf  in  1  1 = LSB received first; 0 = MSB first.
- crc_en  in  1  enable CRC computation and CRC phase.
- rxonly  in  1  receive-only mode.
- shift_in  in  1  serial data bit.
- crc_poly  in  32  CRC polynomial; low N bits are used for an N-bit frame.
- rx_crc_data_out  out  32  running CRC, right-aligned, upper bits zero.
- spi_rx_data  out  32  last completed word, right-aligned, upper bits zero.
- rx_num_max_en  out  1  current data frame is the last one.
- rx_crc_en  out  1  all data frames received; CRC phase active.
- rx_busy  out  1  receiver active.

Behaviour:
- Reset (async, `spi_rx_rstn`=0):
  - All outputs 0.
  - bit_cnt=0, frame_cnt=0, phase=DATA, shift register 0, CRC register 0.
- Frame length N is from `df`. `bit_cnt` counts 0..N-1 and increments every `clk_rx` rise; it wraps to 0 after bit N-1.
- Shift/assemble:
  - MSB-first: `sreg = {sreg[30:0], shift_in}`.
  - LSB-first: `shift_in` is placed at bit position `bit_cnt`.
- On the rise that samples bit N-1 (zero extra latency, because no further clock edge is guaranteed):
  - `spi_rx_data` is loaded with the complete N-bit word, including the current bit, zero-extended.
  - The shift register is cleared.
  - `spi_rx_data` holds until the next frame completes.
- States: DATA, CRC (2-state FSM, transitions at frame completion only).
  - DATA: each completed frame increments `frame_cnt`.
    - On completion with `frame_cnt == spi_tnum_max`: if `crc_en`=1, go to CRC; otherwise `frame_cnt` returns to 0 and the state stays DATA (next transfer).
  - CRC: the next received frame is the transmitted CRC word. It is stored in `spi_rx_data` but not folded into the CRC. On its completion go to DATA with `frame_cnt`=0.
- CRC:
  - Serial, non-reflected, width N, processed in wire order while in DATA with `crc_en`=1.
  - Per bit: `fb = crc[N-1] ^ shift_in`; `crc = ((crc << 1) & mask_N) ^ (fb ? crc_poly & mask_N : 0)`.
  - The register is treated as 0 at the first bit of frame 0 of every transfer (restart).
  - It holds in CRC phase and when `crc_en`=0.
  - `rx_crc_data_out` = register, zero-extended.
- `rx_num_max_en` = (phase==DATA) && (`frame_cnt == spi_tnum_max`). With `spi_tnum_max`=0 it is high for every frame.
- `rx_crc_en` = (phase==CRC).
- `rx_busy` = (`bit_cnt` != 0) || (`rxonly` && (`frame_cnt` != 0 || phase==CRC)). In rxonly mode, busy spans the whole transfer between frames.
- `df`, `lsbf`, `crc_en`, `spi_tnum_max` must be stable for the whole transfer; changes mid-frame give undefined data but no lockup.
- Reset mid-frame or mid-transfer discards all partial state.

Decomposition:
- Shared package: `df` encoding constants (`DF_8`, `DF_16`, `DF_32`), phase enum (DATA, CRC), function `frame_len(df)`, function `mask_n(df)`.
- One natural sub-module: `spi_rx_crc_ser` (serial CRC step with width mask, clear/enable inputs).

Test Plan:
- Reset, then `df`=00, `lsbf`=0, `spi_tnum_max`=1, send 0xA5 MSB-first (8 edges) -> `spi_rx_data`=0x000000A5, `rx_num_max_en`=1 afterward, `rx_busy`=0.
- Reset, `df`=01, `lsbf`=1, send 0xB971 LSB-first (16 edges) -> `spi_rx_data`=0x0000B971.
- Reset, `df`=10, `lsbf`=0, send 0xC3D2F1E8 MSB-first -> `spi_rx_data`=0xC3D2F1E8.
- Reset, `df`=00, `spi_tnum_max`=3, `crc_en`=1, `crc_poly`=0x07; frames 0xA1, 0xB2, 0xC3, 0xD4:
  - `spi_rx_data` follows each frame.
  - `rx_num_max_en` high during frame 4.
  - After frame 4: `rx_crc_data_out`=0x00000025 and `rx_crc_en`=1.
- Reset, `df`=01, `spi_tnum_max`=2, `crc_en`=1, `rxonly`=1; frames 0xA1B2, 0xC3D4, 0xE5F6:
  - Data matches each frame.
  - `rx_busy` stays high between frames.
  - CRC-16 (poly 0x0007) matches the reference model.
  - `rx_crc_en`=1 after frame 3.
- Assert `spi_rx_rstn` low mid-frame -> all outputs 0 immediately; the next frame is received correctly from bit 0.
